// File: rtl/dsp48a1_cmd_sequencer.sv
// Issues operand commands to a DSP48A1 slice and queues its results in issue order with their tags.
// Latency: the first res_valid comes LAT+1 edges after the issue edge when the result queue is empty.
// Backpressure: cmd_ready is a credit test (in-flight + queued < RDEPTH); res_valid holds until res_ready.
module dsp48a1_cmd_sequencer #(
   parameter int         LAT         = 4,
   parameter int         RDEPTH      = 4,
   parameter logic [7:0] IDLE_OPMODE = 8'h08,
   parameter int         TAGW        = 4
) (
   input  logic            clk,
   input  logic            RST,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [17:0]     cmd_a,
   input  logic [17:0]     cmd_b,
   input  logic [47:0]     cmd_c,
   input  logic [17:0]     cmd_d,
   input  logic [7:0]      cmd_opmode,
   input  logic            cmd_carryin,
   input  logic [TAGW-1:0] cmd_tag,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [47:0]     res_p,
   output logic            res_carryout,
   output logic [TAGW-1:0] res_tag,
   output logic [17:0]     dsp_a,
   output logic [17:0]     dsp_b,
   output logic [17:0]     dsp_d,
   output logic [47:0]     dsp_c,
   output logic [7:0]      dsp_opmode,
   output logic            dsp_carryin,
   output logic            dsp_rst,
   output logic            dsp_ce,
   input  logic [47:0]     dsp_p,
   input  logic            dsp_carryout,
   output logic            busy
);

   localparam int CW = $clog2(RDEPTH) + 1;
   localparam int PW = $clog2(RDEPTH);
   localparam int EW = 48 + 1 + TAGW;

   typedef enum logic [1:0] {S_RST, S_INIT, S_RUN} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [3:0]      init_cnt;
   logic            issue;
   logic            capture;
   logic            pop;
   logic            load;
   logic [LAT-1:0]  vld_sh;
   logic [TAGW-1:0] tag_sh [LAT];
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   mcount;
   logic [CW-1:0]   fifo_count;
   logic [CW:0]     credit_used;
   logic [EW-1:0]   mem [RDEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;

   // The queue occupancy includes the entry parked in the output register.
   assign fifo_count  = mcount + {{(CW-1){1'b0}}, res_valid};
   assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
   assign issue       = cmd_valid && cmd_ready;
   assign capture     = vld_sh[LAT-1];
   assign pop         = res_valid && res_ready;
   assign load        = (mcount != '0) && (!res_valid || res_ready);
   assign dsp_ce      = 1'b1;
   assign busy        = (inflight != '0) || (fifo_count != '0);

   // State register.
   always_ff @(posedge clk) begin
      if (RST) state <= S_RST;
      else     state <= state_nxt;
   end

   // Next state, slice reset and the credit-gated command handshake.
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      dsp_rst   = 1'b0;
      case (state)
         S_RST: begin
            dsp_rst   = 1'b1;
            state_nxt = S_INIT;
         end
         S_INIT: begin
            if (init_cnt == 4'd0) state_nxt = S_RUN;
         end
         S_RUN: begin
            cmd_ready = (credit_used < (CW+1)'(RDEPTH));
         end
         default: state_nxt = S_RST;
      endcase
   end

   // Init counter: holds off issue until the slice pipeline has flushed its reset contents.
   always_ff @(posedge clk) begin
      if (RST)                                  init_cnt <= 4'd0;
      else if (state == S_RST)                  init_cnt <= 4'(LAT - 1);
      else if (state == S_INIT && init_cnt != 0) init_cnt <= init_cnt - 4'd1;
   end

   // Slice operand drive: load on issue, otherwise idle opmode so P holds; operands keep last value.
   always_ff @(posedge clk) begin
      if (RST) begin
         dsp_a       <= '0;
         dsp_b       <= '0;
         dsp_c       <= '0;
         dsp_d       <= '0;
         dsp_opmode  <= IDLE_OPMODE;
         dsp_carryin <= 1'b0;
      end else if (issue) begin
         dsp_a       <= cmd_a;
         dsp_b       <= cmd_b;
         dsp_c       <= cmd_c;
         dsp_d       <= cmd_d;
         dsp_opmode  <= cmd_opmode;
         dsp_carryin <= cmd_carryin;
      end else begin
         dsp_opmode  <= IDLE_OPMODE;
         dsp_carryin <= 1'b0;
      end
   end

   // Valid shift line marks the edge at which each command's result sits on dsp_p.
   always_ff @(posedge clk) begin
      if (RST) vld_sh <= '0;
      else     vld_sh <= {vld_sh[LAT-2:0], issue};
   end

   // Tag shift line travels alongside the valid line; only tags with a set valid bit are used.
   always_ff @(posedge clk) begin
      tag_sh[0] <= cmd_tag;
      for (int i = 1; i < LAT; i++) tag_sh[i] <= tag_sh[i-1];
   end

   // In-flight count: commands issued but not yet captured.
   always_ff @(posedge clk) begin
      if (RST) begin
         inflight <= '0;
      end else begin
         case ({issue, capture})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   // Result storage; the credit rule guarantees a free slot whenever a capture arrives.
   always_ff @(posedge clk) begin
      if (capture) mem[wr_ptr] <= {dsp_p, dsp_carryout, tag_sh[LAT-1]};
   end

   // Storage pointers and count of entries not yet moved to the output register.
   always_ff @(posedge clk) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         mcount <= '0;
      end else begin
         if (capture) wr_ptr <= wr_ptr + PW'(1);
         if (load)    rd_ptr <= rd_ptr + PW'(1);
         if (capture && !load)      mcount <= mcount + CW'(1);
         else if (!capture && load) mcount <= mcount - CW'(1);
      end
   end

   // Registered first-word-fall-through output stage.
   always_ff @(posedge clk) begin
      if (RST) begin
         res_valid    <= 1'b0;
         res_p        <= '0;
         res_carryout <= 1'b0;
         res_tag      <= '0;
      end else if (load) begin
         res_valid                        <= 1'b1;
         {res_p, res_carryout, res_tag}   <= mem[rd_ptr];
      end else if (pop) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dsp48a1_cmd_sequencer.sv
// Directed bench for dsp48a1_cmd_sequencer with a behavioural DSP48A1 slice model.
// The slice model updates P LAT-1 edges after the drive edge, so P is stable at the capture edge.
// Carry-in selection in the model is OPMODE5; dsp_carryin is only checked for pass-through.
module tb_dsp48a1_cmd_sequencer;

   localparam int LAT    = 4;
   localparam int RDEPTH = 4;
   localparam int TAGW   = 4;
   localparam int NST    = LAT - 2;

   logic            clk;
   logic            RST;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [17:0]     cmd_a;
   logic [17:0]     cmd_b;
   logic [47:0]     cmd_c;
   logic [17:0]     cmd_d;
   logic [7:0]      cmd_opmode;
   logic            cmd_carryin;
   logic [TAGW-1:0] cmd_tag;
   logic            res_valid;
   logic            res_ready;
   logic [47:0]     res_p;
   logic            res_carryout;
   logic [TAGW-1:0] res_tag;
   logic [17:0]     dsp_a;
   logic [17:0]     dsp_b;
   logic [17:0]     dsp_d;
   logic [47:0]     dsp_c;
   logic [7:0]      dsp_opmode;
   logic            dsp_carryin;
   logic            dsp_rst;
   logic            dsp_ce;
   logic [47:0]     dsp_p;
   logic            dsp_carryout;
   logic            busy;

   int checks;
   int errors;

   dsp48a1_cmd_sequencer #(
      .LAT(LAT), .RDEPTH(RDEPTH), .IDLE_OPMODE(8'h08), .TAGW(TAGW)
   ) dut (
      .clk(clk), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_d(cmd_d),
      .cmd_opmode(cmd_opmode), .cmd_carryin(cmd_carryin), .cmd_tag(cmd_tag),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_p(res_p), .res_carryout(res_carryout), .res_tag(res_tag),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c),
      .dsp_opmode(dsp_opmode), .dsp_carryin(dsp_carryin),
      .dsp_rst(dsp_rst), .dsp_ce(dsp_ce),
      .dsp_p(dsp_p), .dsp_carryout(dsp_carryout),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DSP48A1 behavioural model ----------------
   logic [17:0] st_a [NST];
   logic [17:0] st_b [NST];
   logic [17:0] st_d [NST];
   logic [47:0] st_c [NST];
   logic [7:0]  st_op [NST];

   function automatic logic [48:0] dsp_alu(input logic [17:0] a, input logic [17:0] b,
                                           input logic [17:0] d, input logic [47:0] c,
                                           input logic [7:0] op, input logic [47:0] p);
      logic [17:0]        bb;
      logic signed [35:0] m;
      logic [47:0]        x;
      logic [47:0]        z;
      logic               cin;
      bb  = op[4] ? (op[6] ? d - b : d + b) : b;
      m   = $signed(a) * $signed(bb);
      cin = op[5];
      case (op[1:0])
         2'd0:    x = 48'd0;
         2'd1:    x = {{12{m[35]}}, m};
         2'd2:    x = p;
         default: x = {d[11:0], a, b};
      endcase
      case (op[3:2])
         2'd2:    z = p;
         2'd3:    z = c;
         default: z = 48'd0;
      endcase
      if (op[7]) dsp_alu = {1'b0, z} - ({1'b0, x} + 49'(cin));
      else       dsp_alu = {1'b0, z} + {1'b0, x} + 49'(cin);
   endfunction

   always @(posedge clk) begin
      if (dsp_rst) begin
         for (int i = 0; i < NST; i++) begin
            st_a[i] <= '0; st_b[i] <= '0; st_d[i] <= '0; st_c[i] <= '0; st_op[i] <= '0;
         end
         dsp_p        <= '0;
         dsp_carryout <= 1'b0;
      end else if (dsp_ce) begin
         st_a[0] <= dsp_a; st_b[0] <= dsp_b; st_d[0] <= dsp_d; st_c[0] <= dsp_c; st_op[0] <= dsp_opmode;
         for (int i = 1; i < NST; i++) begin
            st_a[i] <= st_a[i-1]; st_b[i] <= st_b[i-1]; st_d[i] <= st_d[i-1];
            st_c[i] <= st_c[i-1]; st_op[i] <= st_op[i-1];
         end
         {dsp_carryout, dsp_p} <= dsp_alu(st_a[NST-1], st_b[NST-1], st_d[NST-1],
                                          st_c[NST-1], st_op[NST-1], dsp_p);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive_cmd(input logic [17:0] a, input logic [17:0] b, input logic [47:0] c,
                            input logic [17:0] d, input logic [7:0] op, input logic cin,
                            input logic [3:0] tag);
      cmd_a = a; cmd_b = b; cmd_c = c; cmd_d = d;
      cmd_opmode = op; cmd_carryin = cin; cmd_tag = tag;
      cmd_valid = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RST = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({dsp_rst, cmd_ready, res_valid, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: rst/ready/valid/busy=%b expected 1000",
                     {dsp_rst, cmd_ready, res_valid, busy});
         end
         checks++;
         if (dsp_opmode !== 8'h08 || dsp_a !== 18'd0 || dsp_c !== 48'd0 || dsp_carryin !== 1'b0 ||
             res_p !== 48'd0 || res_tag !== 4'd0 || dsp_ce !== 1'b1) begin
            errors++;
            $display("FAIL reset_data: opmode=%h a=%0d c=%0d cin=%b p=%0d tag=%0d ce=%b expected 08 0 0 0 0 0 1",
                     dsp_opmode, dsp_a, dsp_c, dsp_carryin, res_p, res_tag, dsp_ce);
         end
      end
      RST = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         @(negedge clk);
         checks++;
         if (cmd_ready !== 1'b0 || dsp_rst !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL init_hold cycle %0d: ready=%b dsp_rst=%b valid=%b expected 0 0 0",
                     i, cmd_ready, dsp_rst, res_valid);
         end
      end
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL init_done: cmd_ready=%b expected 1", cmd_ready);
      end
   endtask

   task automatic test_single();
      int w;
      res_ready = 1'b1;
      drive_cmd(18'd2, 18'd4, 48'd1, 18'd5, 8'h2D, 1'b1, 4'd3);
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (dsp_a !== 18'd2 || dsp_b !== 18'd4 || dsp_d !== 18'd5 || dsp_c !== 48'd1 ||
          dsp_opmode !== 8'h2D || dsp_carryin !== 1'b1) begin
         errors++;
         $display("FAIL single_drive: a=%0d b=%0d d=%0d c=%0d op=%h cin=%b expected 2 4 5 1 2d 1",
                  dsp_a, dsp_b, dsp_d, dsp_c, dsp_opmode, dsp_carryin);
      end
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_busy: valid=%b busy=%b expected 0 1", res_valid, busy);
      end
      @(negedge clk);
      w = 1;
      checks++;
      if (dsp_opmode !== 8'h08 || dsp_carryin !== 1'b0 || dsp_a !== 18'd2) begin
         errors++;
         $display("FAIL single_idle: op=%h cin=%b a=%0d expected 08 0 2", dsp_opmode, dsp_carryin, dsp_a);
      end
      while (res_valid !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (w !== LAT + 1) begin
         errors++;
         $display("FAIL single_latency: %0d cycles expected %0d", w, LAT + 1);
      end
      checks++;
      if (res_p !== 48'd10 || res_tag !== 4'd3 || res_carryout !== 1'b0) begin
         errors++;
         $display("FAIL single_result: p=%0d tag=%0d co=%b expected 10 3 0", res_p, res_tag, res_carryout);
      end
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_drain: valid=%b busy=%b expected 0 0", res_valid, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  ops   [3];
      logic [47:0] exp_p [3];
      int w;
      ops[0] = 8'h2D; ops[1] = 8'h3D; ops[2] = 8'h31;
      exp_p[0] = 48'd10; exp_p[1] = 48'd20; exp_p[2] = 48'd19;
      res_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready %0d: cmd_ready=%b expected 1", j, cmd_ready);
         end
         drive_cmd(18'd2, 18'd4, 48'd1, 18'd5, ops[j], 1'b1, 4'(j + 1));
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      w = 0;
      while (res_valid !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (res_valid !== 1'b1 || res_p !== exp_p[j] || res_tag !== 4'(j + 1)) begin
            errors++;
            $display("FAIL b2b_result %0d: valid=%b p=%0d tag=%0d expected 1 %0d %0d",
                     j, res_valid, res_p, res_tag, exp_p[j], j + 1);
         end
         @(negedge clk);
      end
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_extra: valid=%b expected 0", res_valid);
      end
   endtask

   task automatic test_backpressure();
      int acc;
      int got;
      res_ready = 1'b0;
      acc = 0;
      cmd_a = 18'd2; cmd_b = 18'd4; cmd_d = 18'd5; cmd_opmode = 8'h2D; cmd_carryin = 1'b1;
      cmd_valid = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         cmd_c   = 48'(100 + acc);
         cmd_tag = 4'(acc);
         if (cmd_ready === 1'b1) acc++;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      checks++;
      if (acc !== RDEPTH || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_credit: accepted=%0d ready=%b expected %0d 0", acc, cmd_ready, RDEPTH);
      end
      repeat (LAT + 2) @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_tag !== 4'd0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_full: valid=%b tag=%0d busy=%b ready=%b expected 1 0 1 0",
                  res_valid, res_tag, busy, cmd_ready);
      end
      res_ready = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (cyc == 1) begin
            checks++;
            if (cmd_ready !== 1'b1) begin
               errors++;
               $display("FAIL bp_reassert: cmd_ready=%b expected 1", cmd_ready);
            end
         end
         if (res_valid === 1'b1) begin
            checks++;
            if (res_tag !== 4'(got) || res_p !== 48'(109 + got)) begin
               errors++;
               $display("FAIL bp_result %0d: p=%0d tag=%0d expected %0d %0d",
                        got, res_p, res_tag, 109 + got, got);
            end
            got++;
         end
         @(negedge clk);
      end
      checks++;
      if (got !== RDEPTH || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_count: delivered=%0d busy=%b expected %0d 0", got, busy, RDEPTH);
      end
   endtask

   task automatic test_feedback();
      res_ready = 1'b0;
      drive_cmd(18'd2, 18'd4, 48'd1, 18'd5, 8'h2D, 1'b1, 4'd5);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (dsp_p !== 48'd10) begin
         errors++;
         $display("FAIL fb_hold: slice P=%0d expected 10", dsp_p);
      end
      drive_cmd(18'd7, 18'd9, 48'd33, 18'd1, 8'h22, 1'b1, 4'd6);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_p !== 48'd10 || res_tag !== 4'd5) begin
         errors++;
         $display("FAIL fb_first: valid=%b p=%0d tag=%0d expected 1 10 5", res_valid, res_p, res_tag);
      end
      res_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_p !== 48'd11 || res_tag !== 4'd6) begin
         errors++;
         $display("FAIL fb_second: valid=%b p=%0d tag=%0d expected 1 11 6", res_valid, res_p, res_tag);
      end
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL fb_extra: valid=%b expected 0", res_valid);
      end
   endtask

   task automatic test_rst_midflight();
      int w;
      int stale;
      res_ready = 1'b0;
      drive_cmd(18'd2, 18'd4, 48'd1, 18'd5, 8'h2D, 1'b1, 4'd7);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      drive_cmd(18'd2, 18'd4, 48'd2, 18'd5, 8'h2D, 1'b1, 4'd8);
      @(negedge clk);
      drive_cmd(18'd2, 18'd4, 48'd3, 18'd5, 8'h2D, 1'b1, 4'd8);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_tag !== 4'd7 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_setup: valid=%b tag=%0d busy=%b expected 1 7 1", res_valid, res_tag, busy);
      end
      RST = 1'b1;
      @(negedge clk);
      RST = 1'b0;
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b0 || dsp_rst !== 1'b1) begin
         errors++;
         $display("FAIL rst_clear: busy=%b valid=%b ready=%b dsp_rst=%b expected 0 0 0 1",
                  busy, res_valid, cmd_ready, dsp_rst);
      end
      w = 0;
      stale = 0;
      while (cmd_ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      res_ready = 1'b1;
      repeat (12) begin
         if (res_valid === 1'b1) stale++;
         @(negedge clk);
      end
      checks++;
      if (w >= 20 || stale !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_stale: wait=%0d stale=%0d busy=%b expected <20 0 0", w, stale, busy);
      end
      drive_cmd(18'd2, 18'd4, 48'd3, 18'd5, 8'h2D, 1'b1, 4'd9);
      @(negedge clk);
      cmd_valid = 1'b0;
      w = 0;
      while (res_valid !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (res_valid !== 1'b1 || res_p !== 48'd12 || res_tag !== 4'd9) begin
         errors++;
         $display("FAIL rst_fresh: valid=%b p=%0d tag=%0d expected 1 12 9", res_valid, res_p, res_tag);
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      RST         = 1'b1;
      cmd_valid   = 1'b0;
      cmd_a       = '0;
      cmd_b       = '0;
      cmd_c       = '0;
      cmd_d       = '0;
      cmd_opmode  = 8'h08;
      cmd_carryin = 1'b0;
      cmd_tag     = '0;
      res_ready   = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_feedback();
      test_rst_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dsp48a1_cmd_sequencer.md
Name: dsp48a1_cmd_sequencer

Overview:
- Initiator-side controller for the DSP48A1 slice (DSP_Top). It takes operation commands over a valid/ready stream and drives the slice's A/B/C/D/OPMODE/CARRYIN ports.
- It tracks each command through the slice's fixed pipeline latency and captures P/CARRYOUT into a result FIFO, presented on a valid/ready stream with the command tag.
- Replaces hand-timed stimulus with a credit-controlled issue engine usable in system integration.

Parameters:
- LAT, 4: cycles from the dsp_* drive edge to the edge where dsp_p/dsp_carryout hold that command's result. Legal range 2..15.
- RDEPTH, 4: result FIFO depth. Power of 2, 2..16.
- IDLE_OPMODE, 8'h08: OPMODE driven on non-issue cycles. X=0, Z=P, add, OPMODE5=0, so P holds its value.
- TAGW, 4: tag width.

Ports:
- clk  in  1  rising-edge clock
- RST  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_a  in  18  A operand
- cmd_b  in  18  B operand
- cmd_c  in  48  C operand
- cmd_d  in  18  D operand
- cmd_opmode  in  8  OPMODE for this command
- cmd_carryin  in  1  CARRYIN for this command
- cmd_tag  in  TAGW  user tag
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid&&res_ready
- res_p  out  48  captured P
- res_carryout  out  1  captured CARRYOUT
- res_tag  out  TAGW  tag of the result
- dsp_a, dsp_b, dsp_d  out  18  to DSP_Top A/B/D
- dsp_c  out  48  to DSP_Top C
- dsp_opmode  out  8  to DSP_Top opmode
- dsp_carryin  out  1  to DSP_Top CARRYIN
- dsp_rst  out  1  drives all DSP_Top RSTx
- dsp_ce  out  1  drives all DSP_Top CEx
- dsp_p  in  48  DSP_Top P
- dsp_carryout  in  1  DSP_Top CARRYOUT
- busy  out  1  in-flight count or FIFO occupancy nonzero

Behaviour:
- FSM states: S_RST, S_INIT, S_RUN.
- RST=1: state goes to S_RST at the next edge. Reset values: dsp_rst=1, dsp_ce=1, cmd_ready=0, res_valid=0, busy=0, FIFO empty, in-flight=0, valid-shift=0, dsp_opmode=IDLE_OPMODE, dsp_a/b/c/d=0, dsp_carryin=0, res_p=0, res_carryout=0, res_tag=0.
- S_RST with RST=0: go to S_INIT and load counter with LAT-1. dsp_rst deasserts on the same edge.
- S_INIT: counter decrements each cycle. At 0, go to S_RUN. dsp_rst=0 and cmd_ready=0 throughout, so stale slice pipeline contents are never captured.
- S_RUN: cmd_ready = (inflight + fifo_count < RDEPTH), registered-free combinational. This credit rule makes FIFO overflow impossible.
- Issue: when cmd_valid&&cmd_ready, register cmd_a/b/c/d/opmode/carryin onto dsp_* at that edge. Set bit 0 of a LAT-long valid/tag shift line.
- No issue: dsp_opmode=IDLE_OPMODE and dsp_carryin=0. dsp_a/b/c/d hold their last values.
- Back-to-back issues are allowed, one per cycle. Feedback commands (X=2 or Z=2) see the P of the preceding command plus any IDLE holds.
- Capture: when the shift line's bit LAT-1 is set, push {dsp_p, dsp_carryout, tag} into the FIFO at that edge. The result's first res_valid cycle is LAT+1 edges after the issue edge when the FIFO is empty.
- in-flight: +1 on issue, -1 on capture. Both in one cycle leave it unchanged.
- FIFO: first-word-fall-through, registered outputs. Push and pop in the same cycle at any occupancy, including full with pop, are legal and lossless. Results leave in issue order.
- res_valid holds, and res_p/res_carryout/res_tag are stable, until res_ready.
- RST mid-operation: all in-flight work and FIFO contents are discarded. No res_valid appears until new commands are issued after S_INIT.
- Arithmetic is entirely inside DSP_Top. The sequencer performs no width changes; values pass through verbatim.

Test Plan:
- Reset/init: RST high 3 cycles then low → dsp_rst=1 during RST. cmd_ready stays 0 for LAT cycles after RST falls, then goes 1. res_valid=0 throughout.
- Single command: A=2, B=4, C=1, D=5, opmode=8'h2D, CARRYINSEL=OPMODE5, tag=3 → res_valid at issue+LAT+1, res_p=10, res_tag=3.
- Back-to-back: opmode 8'h2D (tag 1), 8'h3D (tag 2), 8'h31 (tag 3) on consecutive cycles, res_ready=1 → results 10, 20, 19 on three consecutive cycles, in tag order.
- Backpressure: res_ready=0, issue continuously → exactly RDEPTH commands accepted, then cmd_ready=0. Raise res_ready → all RDEPTH results delivered with no loss or duplication. cmd_ready reasserts the cycle after the first pop.
- P hold/feedback: issue 8'h2D (P=10), idle 5 cycles, issue 8'h22 (Z=0, X=P, OPMODE5=1) → second result 11. Idle cycles keep P at 10.
- RST mid-flight: with 2 commands in flight and 1 result queued, pulse RST for 1 cycle → busy=0 and res_valid=0 next cycle. No stale result emerges after re-init.
